mips_multicycle_core: RTL and testbench

Parametrised multi-cycle MIPS core: controller FSM and datapath in one block, sharing one instruction/data memory port with a ready handshake. It replaces the single-cycle datapath and its external control: each instruction takes 2–5 cycles, plus memory wait states. It sits between the top level and a single memory model.

---
 rtl/mips_mc_pkg.sv | 55 +++++
 rtl/mips_mc_regfile.sv | 35 +++
 rtl/mips_multicycle_core.sv | 172 +++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, funct codes,
// controller states, ALU operations and instruction legality.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    function automatic alu_op_t funct_to_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                             (fn == FN_OR)  || (fn == FN_SLT);
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// NREG x XLEN register file: two asynchronous read ports, one synchronous
// write port, register 0 hard-wired to zero, synchronous clear on reset.
module mips_mc_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RIDX-1:0] rs_addr,
    input  logic [RIDX-1:0] rt_addr,
    input  logic            we,
    input  logic [RIDX-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rs_data,
    output logic [XLEN-1:0] rt_data
);
    import mips_mc_pkg::*;

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: one FSM drives fetch/decode/execute/memory/writeback
// over a single shared memory port with a ready handshake.
module mips_multicycle_core #(
    parameter int                XLEN     = 32,
    parameter int                NREG     = 32,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ready,
    output logic              halt,
    output logic [ADDR_W-1:0] pc_out
);
    import mips_mc_pkg::*;

    localparam int RIDX = $clog2(NREG);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   mdr;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [RIDX-1:0]   rs_idx;
    logic [RIDX-1:0]   rt_idx;
    logic [RIDX-1:0]   rd_idx;
    logic [RIDX-1:0]   wr_idx;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [XLEN-1:0]   wr_data;
    logic [XLEN-1:0]   alu_b;
    logic [XLEN-1:0]   alu_y;
    logic [ADDR_W-1:0] jump_pc;
    logic              reg_we;
    alu_op_t           alu_op;

    assign opcode  = ir[31:26];
    assign funct   = ir[5:0];
    assign rs_idx  = ir[21 +: RIDX];
    assign rt_idx  = ir[16 +: RIDX];
    assign rd_idx  = ir[11 +: RIDX];
    assign imm_ext = XLEN'($signed(ir[15:0]));

    // The 28-bit jump target replaces the low PC bits; wider PCs keep their top bits.
    if (ADDR_W > 28) begin : g_wide_jump
        assign jump_pc = {pc[ADDR_W-1:28], ir[25:0], 2'b00};
    end else begin : g_narrow_jump
        assign jump_pc = ADDR_W'({ir[25:0], 2'b00});
    end

    always_comb begin
        alu_op = (opcode == OP_RTYPE) ? funct_to_alu(funct) : ALU_ADD;
        alu_b  = (opcode == OP_RTYPE) ? b : imm_ext;
        alu_y  = a + alu_b;
        case (alu_op)
            ALU_SUB: alu_y = a - alu_b;
            ALU_AND: alu_y = a & alu_b;
            ALU_OR:  alu_y = a | alu_b;
            ALU_SLT: alu_y = ($signed(a) < $signed(alu_b)) ? XLEN'(1) : '0;
            default: alu_y = a + alu_b;
        endcase
    end

    assign reg_we  = (state == S_WB);
    assign wr_idx  = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
    assign wr_data = (opcode == OP_LW) ? mdr : alu_out;

    mips_mc_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .RIDX (RIDX)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rs_addr (rs_idx),
        .rt_addr (rt_idx),
        .we      (reg_we),
        .wr_addr (wr_idx),
        .wr_data (wr_data),
        .rs_data (rs_data),
        .rt_data (rt_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= 32'(mem_rdata);
                        pc    <= pc + ADDR_W'(4);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a       <= rs_data;
                    b       <= rt_data;
                    alu_out <= XLEN'(pc) + (imm_ext << 2);
                    if (!is_legal(opcode, funct)) begin
                        state <= S_HALT;
                    end else if (opcode == OP_J) begin
                        pc    <= jump_pc;
                        state <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_RTYPE, OP_ADDI: begin
                            alu_out <= alu_y;
                            state   <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_out <= alu_y;
                            state   <= S_MEM;
                        end
                        OP_BEQ: begin
                            if (a == b) pc <= alu_out[ADDR_W-1:0];
                            state <= S_FETCH;
                        end
                        OP_BNE: begin
                            if (a != b) pc <= alu_out[ADDR_W-1:0];
                            state <= S_FETCH;
                        end
                        default: state <= S_HALT;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (opcode == OP_LW) begin
                            mdr   <= mem_rdata;
                            state <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    // Requests decode from the registered state only; reset gates them off immediately.
    assign mem_read  = !reset && ((state == S_FETCH) || ((state == S_MEM) && (opcode == OP_LW)));
    assign mem_write = !reset && (state == S_MEM) && (opcode == OP_SW);
    assign mem_addr  = (state == S_MEM) ? alu_out[ADDR_W-1:0] : pc;
    assign mem_wdata = b;
    assign halt      = (state == S_HALT);
    assign pc_out    = pc;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: a small program in a word memory,
// cycle-exact checks of the memory port, PC and halt behaviour.
module tb_mips_multicycle_core;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_ready;
    logic              mem_read;
    logic              mem_write;
    logic              halt;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] pc_out;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    logic [31:0] mem [64];
    int checks = 0;
    int errors = 0;

    mips_multicycle_core #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .ADDR_W   (ADDR_W),
        .RESET_PC (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_ready (mem_ready),
        .halt      (halt),
        .pc_out    (pc_out)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    task automatic applyStimulus(input logic rst, input logic rdy);
        reset     = rst;
        mem_ready = rdy;
    endtask

    // Each cycle: sample the write request mid-cycle, commit it at the edge, then settle.
    task automatic tick(input int n);
        logic        wr;
        logic [5:0]  wa;
        logic [31:0] wd;
        repeat (n) begin
            @(negedge clk);
            wr = mem_write && mem_ready;
            wa = mem_addr[7:2];
            wd = mem_wdata;
            @(posedge clk);
            if (wr) mem[wa] = wd;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  st_addr [6];
        logic [31:0] st_data [6];
        st_addr = '{8'hC0, 8'hC4, 8'hC8, 8'hCC, 8'hD0, 8'hD4};
        st_data = '{32'd2, 32'd1, 32'd5, 32'd7, 32'd1, 32'hFFFF_FFFF};

        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h2001_0005;   // 00 addi $1,$0,5
        mem[1]  = 32'h2002_0007;   // 04 addi $2,$0,7
        mem[2]  = 32'h0022_1820;   // 08 add  $3,$1,$2
        mem[3]  = 32'h0800_0008;   // 0C j    0x20
        mem[4]  = 32'hDEAD_BEEF;   // 10 data
        mem[8]  = 32'hAC03_0010;   // 20 sw   $3,0x10($0)
        mem[9]  = 32'h8C04_0010;   // 24 lw   $4,0x10($0)
        mem[10] = 32'hAC04_0014;   // 28 sw   $4,0x14($0)
        mem[11] = 32'h1021_0002;   // 2C beq  $1,$1,+2
        mem[14] = 32'h1421_0002;   // 38 bne  $1,$1,+2
        mem[15] = 32'h1422_0001;   // 3C bne  $1,$2,+1
        mem[16] = 32'hFC00_0000;   // 40 illegal, must be skipped
        mem[17] = 32'h0041_2822;   // 44 sub  $5,$2,$1
        mem[18] = 32'h0022_302A;   // 48 slt  $6,$1,$2
        mem[19] = 32'h0022_3824;   // 4C and  $7,$1,$2
        mem[20] = 32'h0022_4025;   // 50 or   $8,$1,$2
        mem[21] = 32'h2009_FFFF;   // 54 addi $9,$0,-1
        mem[22] = 32'h0121_502A;   // 58 slt  $10,$9,$1
        mem[23] = 32'hAC05_00C0;   // 5C sw   $5,0xC0
        mem[24] = 32'hAC06_00C4;   // 60 sw   $6,0xC4
        mem[25] = 32'hAC07_00C8;   // 64 sw   $7,0xC8
        mem[26] = 32'hAC08_00CC;   // 68 sw   $8,0xCC
        mem[27] = 32'hAC0A_00D0;   // 6C sw   $10,0xD0
        mem[28] = 32'hAC09_00D4;   // 70 sw   $9,0xD4
        mem[29] = 32'h2000_0009;   // 74 addi $0,$0,9
        mem[30] = 32'hAC00_00D8;   // 78 sw   $0,0xD8
        mem[31] = 32'hAC03_00DC;   // 7C sw   $3,0xDC
        mem[55] = 32'hA5A5_A5A5;   // DC data

        tick(2);
        checkOutput("reset_mem_read", 32'(mem_read), 32'd0);
        checkOutput("reset_mem_write", 32'(mem_write), 32'd0);
        checkOutput("reset_halt", 32'(halt), 32'd0);
        checkOutput("reset_pc", 32'(pc_out), 32'h00);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'h00);
        checkOutput("reset_wdata", mem_wdata, 32'd0);

        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("first_fetch_read", 32'(mem_read), 32'd1);
        checkOutput("first_fetch_addr", 32'(mem_addr), 32'h00);
        tick(1);
        checkOutput("pc_after_fetch", 32'(pc_out), 32'h04);
        tick(11);
        checkOutput("three_alu_pc", 32'(pc_out), 32'h0C);
        checkOutput("three_alu_fetch", 32'(mem_addr), 32'h0C);

        tick(2);
        checkOutput("j_target", 32'(mem_addr), 32'h20);

        tick(3);
        checkOutput("sw_mem_write", 32'(mem_write), 32'd1);
        checkOutput("sw_mem_read", 32'(mem_read), 32'd0);
        checkOutput("sw_addr", 32'(mem_addr), 32'h10);
        checkOutput("sw_wdata_r3", mem_wdata, 32'd12);
        tick(1);
        checkOutput("sw_memory", mem[4], 32'd12);
        checkOutput("sw_next_fetch", 32'(mem_addr), 32'h24);

        tick(3);
        checkOutput("lw_mem_read", 32'(mem_read), 32'd1);
        checkOutput("lw_addr", 32'(mem_addr), 32'h10);
        applyStimulus(1'b0, 1'b0);
        tick(3);
        checkOutput("lw_stall_read", 32'(mem_read), 32'd1);
        checkOutput("lw_stall_addr", 32'(mem_addr), 32'h10);
        applyStimulus(1'b0, 1'b1);
        tick(2);
        checkOutput("lw_retire_fetch", 32'(mem_addr), 32'h28);
        checkOutput("lw_retire_pc", 32'(pc_out), 32'h28);

        applyStimulus(1'b0, 1'b0);
        tick(3);
        checkOutput("fetch_stall_read", 32'(mem_read), 32'd1);
        checkOutput("fetch_stall_addr", 32'(mem_addr), 32'h28);
        checkOutput("fetch_stall_pc", 32'(pc_out), 32'h28);
        applyStimulus(1'b0, 1'b1);
        tick(3);
        checkOutput("sw_r4_write", 32'(mem_write), 32'd1);
        checkOutput("sw_r4_addr", 32'(mem_addr), 32'h14);
        checkOutput("sw_r4_wdata", mem_wdata, 32'd12);
        tick(1);
        checkOutput("after_sw_r4", 32'(mem_addr), 32'h2C);

        tick(3);
        checkOutput("beq_taken", 32'(mem_addr), 32'h38);
        tick(3);
        checkOutput("bne_not_taken", 32'(mem_addr), 32'h3C);
        tick(3);
        checkOutput("bne_taken", 32'(mem_addr), 32'h44);
        checkOutput("no_halt_yet", 32'(halt), 32'd0);

        tick(24);
        checkOutput("alu_block_pc", 32'(pc_out), 32'h5C);
        for (int i = 0; i < 6; i++) begin
            tick(3);
            checkOutput("alu_store_addr", 32'(mem_addr), 32'(st_addr[i]));
            checkOutput("alu_store_data", mem_wdata, st_data[i]);
            tick(1);
        end

        tick(4);
        tick(3);
        checkOutput("r0_stays_zero", mem_wdata, 32'd0);
        tick(1);

        tick(3);
        checkOutput("sw_before_reset", 32'(mem_write), 32'd1);
        applyStimulus(1'b0, 1'b0);
        tick(1);
        checkOutput("sw_wait_held_write", 32'(mem_write), 32'd1);
        checkOutput("sw_wait_held_addr", 32'(mem_addr), 32'hDC);
        applyStimulus(1'b1, 1'b1);
        #1;
        checkOutput("reset_drops_write", 32'(mem_write), 32'd0);
        checkOutput("reset_drops_read", 32'(mem_read), 32'd0);
        tick(1);
        checkOutput("memory_unwritten", mem[55], 32'hA5A5_A5A5);
        checkOutput("reset_pc_again", 32'(pc_out), 32'h00);

        mem[0] = 32'hFC00_0000;
        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("refetch_read", 32'(mem_read), 32'd1);
        checkOutput("refetch_addr", 32'(mem_addr), 32'h00);
        tick(1);
        checkOutput("decode_not_halted", 32'(halt), 32'd0);
        tick(1);
        checkOutput("halt_set", 32'(halt), 32'd1);
        checkOutput("halt_no_read", 32'(mem_read), 32'd0);
        checkOutput("halt_pc", 32'(pc_out), 32'h04);
        tick(5);
        checkOutput("halt_sticky", 32'(halt), 32'd1);
        checkOutput("halt_still_no_read", 32'(mem_read), 32'd0);
        checkOutput("halt_no_write", 32'(mem_write), 32'd0);
        checkOutput("halt_pc_frozen", 32'(pc_out), 32'h04);

        applyStimulus(1'b1, 1'b1);
        tick(1);
        checkOutput("reset_clears_halt", 32'(halt), 32'd0);
        checkOutput("reset_clears_pc", 32'(pc_out), 32'h00);
        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("post_halt_fetch_read", 32'(mem_read), 32'd1);
        checkOutput("post_halt_fetch_addr", 32'(mem_addr), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
